// File: rtl/universal_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | universal_reg: WIDTH-bit register with load/shift/rotate/inc/dec modes,    |
// | registered true/complement outputs, carry flag and combinational zero.     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module universal_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               ARITH_SR  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b,
  output logic             co,
  output logic             zero
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] inv_q, inv_d;
  logic             co_q, co_d;
  logic             msb_in;

  always_comb begin
    data_d = data_q;
    co_d   = co_q;
    msb_in = ARITH_SR ? data_q[WIDTH-1] : sin_r;
    if (clr) begin
      data_d = '0;
      co_d   = 1'b0;
    end else if (en) begin
      unique case (op)
        OP_HOLD: begin
          data_d = data_q;
          co_d   = co_q;
        end
        OP_LOAD: begin
          data_d = d;
          co_d   = 1'b0;
        end
        OP_SHL: begin
          data_d = {data_q[WIDTH-2:0], sin_l};
          co_d   = data_q[WIDTH-1];
        end
        OP_SHR: begin
          data_d = {msb_in, data_q[WIDTH-1:1]};
          co_d   = data_q[0];
        end
        OP_ROL: begin
          data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          co_d   = data_q[WIDTH-1];
        end
        OP_ROR: begin
          data_d = {data_q[0], data_q[WIDTH-1:1]};
          co_d   = data_q[0];
        end
        // The extra top bit of the widened sum/difference is the carry/borrow.
        OP_INC: {co_d, data_d} = {1'b0, data_q} + (WIDTH+1)'(1);
        OP_DEC: {co_d, data_d} = {1'b0, data_q} - (WIDTH+1)'(1);
      endcase
    end
  end

  // Complement kept as its own register so q_b has no inverter on its output path.
  assign inv_d = ~data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
      inv_q  <= ~RESET_VAL;
      co_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      inv_q  <= inv_d;
      co_q   <= co_d;
    end
  end

  assign q    = data_q;
  assign q_b  = inv_q;
  assign co   = co_q;
  assign zero = (data_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_universal_reg.sv
`default_nettype none
// Scoreboard bench for universal_reg: a logical-shift and an arithmetic-shift
// instance share stimulus; expected values are hand-computed per step.
module tb_universal_reg;
  localparam int           W  = 16;
  localparam logic [W-1:0] RV = 16'h00A5;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
  localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, INC = 3'b110, DEC = 3'b111;

  logic         clk = 1'b0, rst = 1'b0, clr = 1'b0, en = 1'b0;
  logic         sin_l = 1'b0, sin_r = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] d = '0;

  logic [W-1:0] q_l, qb_l, q_a, qb_a;
  logic         co_l, co_a, zero_l, zero_a;

  universal_reg #(.WIDTH(W), .RESET_VAL(RV), .ARITH_SR(1'b0)) u_log (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .op(op), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q_l), .q_b(qb_l), .co(co_l), .zero(zero_l)
  );

  universal_reg #(.WIDTH(W), .RESET_VAL(RV), .ARITH_SR(1'b1)) u_ari (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .op(op), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q_a), .q_b(qb_a), .co(co_a), .zero(zero_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         co;
    logic [W-1:0] qa;
    logic         coa;
    int           id;
  } exp_t;

  exp_t sb[$];
  event async_ev;
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  task automatic chk(input string name, input int id, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: output is presented after every rising edge and after an async reset.
  initial begin
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("q",      e.id, q_l,          e.q);
        chk("q_b",    e.id, qb_l,         ~e.q);
        chk("co",     e.id, W'(co_l),     W'(e.co));
        chk("zero",   e.id, W'(zero_l),   W'(e.q == '0));
        chk("q_ari",  e.id, q_a,          e.qa);
        chk("qb_ari", e.id, qb_a,         ~e.qa);
        chk("co_ari", e.id, W'(co_a),     W'(e.coa));
      end
    end
  end

  task automatic step2(input logic e_en, input logic c, input logic [2:0] o, input logic [W-1:0] dd,
                       input logic sl, input logic sr, input logic [W-1:0] eq, input logic eco,
                       input logic [W-1:0] eqa, input logic ecoa);
    @(negedge clk);
    rst = 1'b0; en = e_en; clr = c; op = o; d = dd; sin_l = sl; sin_r = sr;
    step_id++;
    sb.push_back('{q: eq, co: eco, qa: eqa, coa: ecoa, id: step_id});
  endtask

  task automatic step(input logic e_en, input logic c, input logic [2:0] o, input logic [W-1:0] dd,
                      input logic sl, input logic sr, input logic [W-1:0] eq, input logic eco);
    step2(e_en, c, o, dd, sl, sr, eq, eco, eq, eco);
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2;
    rst = 1'b1;
    step_id++;
    sb.push_back('{q: RV, co: 1'b0, qa: RV, coa: 1'b0, id: step_id});
    -> async_ev;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset between edges, then hold with en=0.
    async_rst();
    step(0, 0, INC,  16'h1234, 1, 1, RV, 0);
    step(0, 0, INC,  16'h1234, 1, 1, RV, 0);
    step(0, 0, LOAD, 16'h1234, 1, 1, RV, 0);

    // Load then clear (clear beats op).
    step(1, 0, LOAD, 16'h8001, 0, 0, 16'h8001, 0);
    step(1, 1, INC,  16'hFFFF, 0, 0, 16'h0000, 0);

    // Shift and rotate.
    step(1, 0, LOAD, 16'h8001, 0, 0, 16'h8001, 0);
    step(1, 0, SHL,  16'hFFFF, 1, 0, 16'h0003, 1);
    step(1, 0, SHR,  16'hFFFF, 0, 0, 16'h0001, 1);
    step(1, 0, LOAD, 16'h8000, 0, 0, 16'h8000, 0);
    step2(1, 0, SHR, 16'hFFFF, 0, 0, 16'h4000, 0, 16'hC000, 0);
    step(1, 0, LOAD, 16'h8000, 0, 0, 16'h8000, 0);
    step2(1, 0, SHR, 16'h0000, 0, 1, 16'hC000, 0, 16'hC000, 0);
    step(1, 0, LOAD, 16'h8001, 0, 0, 16'h8001, 0);
    step(1, 0, ROR,  16'h0000, 0, 0, 16'hC000, 1);
    step(1, 0, LOAD, 16'h8001, 0, 0, 16'h8001, 0);
    step(1, 0, ROL,  16'h0000, 0, 0, 16'h0003, 1);
    step(1, 0, HOLD, 16'hFFFF, 0, 0, 16'h0003, 1);

    // Counter wrap both directions.
    step(1, 0, LOAD, 16'hFFFE, 0, 0, 16'hFFFE, 0);
    step(1, 0, INC,  16'h0000, 0, 0, 16'hFFFF, 0);
    step(1, 0, INC,  16'h0000, 0, 0, 16'h0000, 1);
    step(1, 0, DEC,  16'h0000, 0, 0, 16'hFFFF, 1);
    step(1, 0, DEC,  16'h0000, 0, 0, 16'hFFFE, 0);

    // Enable gating and clear-over-disable priority.
    step(1, 0, LOAD, 16'h0005, 0, 0, 16'h0005, 0);
    step(1, 0, INC,  16'h0000, 0, 0, 16'h0006, 0);
    step(0, 0, INC,  16'h0000, 0, 0, 16'h0006, 0);
    step(1, 0, INC,  16'h0000, 0, 0, 16'h0007, 0);
    step(0, 1, INC,  16'h0000, 0, 0, 16'h0000, 0);

    // Count up from zero, then abort with an asynchronous reset.
    for (int i = 1; i <= 10; i++)
      step(1, 0, INC, 16'h0000, 0, 0, W'(i), 0);
    async_rst();
    step(1, 0, INC, 16'h0000, 0, 0, RV + 16'h0001, 0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL pending: got %0d unchecked entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
